// File: rtl/regfile_rr_arbiter_if.sv
// Requester command/response bus and register-file access bus used by regfile_rr_arbiter.
interface regfile_rr_arbiter_if #(parameter int AW = 5);
    logic          req;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          write;
    logic [31:0]   wdata;
    logic          ack;
    logic [31:0]   rdata;
    logic          err;

    modport master (output req, addr, size, write, wdata, input ack, rdata, err);
    modport slave  (input req, addr, size, write, wdata, output ack, rdata, err);
endinterface

interface regfile_rr_arbiter_rf_if #(parameter int AW = 5);
    logic          en;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          we;
    logic          re;
    logic [31:0]   wd_data;
    logic [31:0]   rd_data;
    logic          done;
    logic          check;

    modport master (output en, addr, size, we, re, wd_data, input rd_data, done, check);
    modport slave  (input en, addr, size, we, re, wd_data, output rd_data, done, check);
endinterface

// File: rtl/regfile_rr_arbiter.sv
// Two-requester round-robin arbiter sequencing single accesses into the byte-addressed
// register file, with registered response, one-cycle ack and bounded wait on rf done.
module regfile_rr_arbiter_lane #(
    parameter logic LANE_ID = 1'b0
) (
    input  logic        rsp_vld,
    input  logic        rsp_id,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);
    // Response fields are gated so a non-acked requester always sees zeros.
    assign ack   = rsp_vld && (rsp_id == LANE_ID);
    assign rdata = ack ? rsp_rdata : 32'd0;
    assign err   = ack && rsp_err;
endmodule

module regfile_rr_arbiter #(
    parameter  int REG_DEPTH = 32,
    parameter  int TIMEOUT   = 16,
    localparam int AW        = $clog2(REG_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_rr_arbiter_if.slave      m0,
    regfile_rr_arbiter_if.slave      m1,
    regfile_rr_arbiter_rf_if.master  rf
);
    localparam int NUM_REQ = 2;
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;

    logic [NUM_REQ-1:0]          req_v;
    logic [NUM_REQ-1:0][AW-1:0]  addr_v;
    logic [NUM_REQ-1:0][1:0]     size_v;
    logic [NUM_REQ-1:0]          write_v;
    logic [NUM_REQ-1:0][31:0]    wdata_v;
    logic [NUM_REQ-1:0]          ack_v;
    logic [NUM_REQ-1:0][31:0]    rdata_v;
    logic [NUM_REQ-1:0]          err_v;

    logic          win;
    logic          rr_last;
    logic          cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_size;
    logic          cmd_write;
    logic [31:0]   cmd_wdata;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          rsp_vld;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    assign req_v   = {m1.req,   m0.req};
    assign addr_v  = {m1.addr,  m0.addr};
    assign size_v  = {m1.size,  m0.size};
    assign write_v = {m1.write, m0.write};
    assign wdata_v = {m1.wdata, m0.wdata};

    // On a tie the requester that did not win last time goes first.
    assign win         = (req_v[0] && req_v[1]) ? ~rr_last : req_v[1];
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_v) state_nxt = (size_v[win] == 2'b11) ? RESP : ACCESS;
            ACCESS:  if (rf.done || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last   <= 1'b1;
            cmd_id    <= 1'b0;
            cmd_addr  <= '0;
            cmd_size  <= '0;
            cmd_write <= 1'b0;
            cmd_wdata <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_v) begin
                    cmd_id    <= win;
                    rr_last   <= win;
                    cmd_addr  <= addr_v[win];
                    cmd_size  <= size_v[win];
                    cmd_write <= write_v[win];
                    cmd_wdata <= wdata_v[win];
                    rsp_rdata <= '0;
                    rsp_err   <= (size_v[win] == 2'b11);
                end
                ACCESS: begin
                    if (rf.done) begin
                        rsp_err   <= rf.check;
                        rsp_rdata <= (cmd_write || rf.check) ? 32'd0 : rf.rd_data;
                        wait_cnt  <= '0;
                    end else if (timeout_hit) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rf.en      = 1'b0;
        rf.we      = 1'b0;
        rf.re      = 1'b0;
        rf.addr    = '0;
        rf.size    = '0;
        rf.wd_data = '0;
        rsp_vld    = (state == RESP);
        if (state == ACCESS) begin
            rf.en      = 1'b1;
            rf.we      = cmd_write;
            rf.re      = !cmd_write;
            rf.addr    = cmd_addr;
            rf.size    = cmd_size;
            rf.wd_data = cmd_wdata;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        regfile_rr_arbiter_lane #(.LANE_ID(1'(i))) u_lane (
            .rsp_vld   (rsp_vld),
            .rsp_id    (cmd_id),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err),
            .ack       (ack_v[i]),
            .rdata     (rdata_v[i]),
            .err       (err_v[i])
        );
    end

    assign m0.ack   = ack_v[0];
    assign m0.rdata = rdata_v[0];
    assign m0.err   = err_v[0];
    assign m1.ack   = ack_v[1];
    assign m1.rdata = rdata_v[1];
    assign m1.err   = err_v[1];
endmodule

// File: tb/tb_regfile_rr_arbiter.sv
// Bench for regfile_rr_arbiter: bench-side register file slave, transaction-level
// reference model compared every cycle, directed literal checks and random traffic.
module tb_regfile_rr_arbiter;
    localparam int AW      = 5;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_rr_arbiter_if    #(.AW(AW)) m0_if ();
    regfile_rr_arbiter_if    #(.AW(AW)) m1_if ();
    regfile_rr_arbiter_rf_if #(.AW(AW)) rf_if ();

    regfile_rr_arbiter #(.REG_DEPTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .rf  (rf_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic bad_acc(input logic [AW-1:0] a, input logic [1:0] s);
        return (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00) || (s == 2'd3);
    endfunction

    // ---------------- register file slave (environment) ----------------
    logic [7:0] mem [32];
    int acc_cyc = 0;
    int stall_cfg = 0;   // done-low cycles before done; >= TIMEOUT forces an abort

    always_comb begin
        rf_if.rd_data = '0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(rf_if.size)) rf_if.rd_data[8*i +: 8] = mem[(int'(rf_if.addr) + i) % 32];
        rf_if.check = rf_if.en && bad_acc(rf_if.addr, rf_if.size);
        rf_if.done  = rf_if.en && (acc_cyc >= stall_cfg);
    end

    always @(posedge clk) begin
        if (rf_if.en && rf_if.we && rf_if.done && !rf_if.check)
            for (int i = 0; i < 4; i++)
                if (i < nbytes(rf_if.size)) mem[(int'(rf_if.addr) + i) % 32] <= rf_if.wd_data[8*i +: 8];
        acc_cyc <= rf_if.en ? acc_cyc + 1 : 0;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  mmem [32];
    bit          m_busy, m_rr, m_id, m_write, m_err, m_wr;
    int          m_cnt, m_len;     // m_cnt: cycle index since grant; m_len: access cycles
    logic [4:0]  m_addr;
    logic [1:0]  m_size;
    logic [31:0] m_wdata, m_rd;

    function automatic logic [31:0] mread(input logic [4:0] a, input logic [1:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(s)) r[8*i +: 8] = mmem[(int'(a) + i) % 32];
        return r;
    endfunction

    bit g_win, g_write, g_chk, g_to, g_err;
    logic [4:0] g_addr;
    logic [1:0] g_size;
    logic [31:0] g_wdata, g_rd;
    int g_len;

    always_comb begin
        g_win   = (m0_if.req && m1_if.req) ? !m_rr : m1_if.req;
        g_addr  = g_win ? m1_if.addr  : m0_if.addr;
        g_size  = g_win ? m1_if.size  : m0_if.size;
        g_write = g_win ? m1_if.write : m0_if.write;
        g_wdata = g_win ? m1_if.wdata : m0_if.wdata;
        g_chk   = bad_acc(g_addr, g_size);
        g_to    = (TIMEOUT != 0) && (stall_cfg >= TIMEOUT);
        g_len   = 0;
        g_err   = 1'b1;
        g_rd    = '0;
        if (g_size != 2'd3) begin
            if (g_to) g_len = TIMEOUT;
            else begin
                g_len = stall_cfg + 1;
                g_err = g_chk;
                if (!g_write && !g_chk) g_rd = mread(g_addr, g_size);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rr   <= 1'b1;
            m_cnt  <= 0;
            m_wr   <= 1'b0;
        end else if (!m_busy) begin
            if (m0_if.req || m1_if.req) begin
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                m_rr    <= g_win;
                m_id    <= g_win;
                m_addr  <= g_addr;
                m_size  <= g_size;
                m_write <= g_write;
                m_wdata <= g_wdata;
                m_len   <= g_len;
                m_err   <= g_err;
                m_rd    <= g_rd;
                m_wr    <= g_write && (g_size != 2'd3) && !g_to && !g_chk;
            end
        end else begin
            if (m_cnt == m_len && m_wr)
                for (int i = 0; i < 4; i++)
                    if (i < nbytes(m_size)) mmem[(int'(m_addr) + i) % 32] <= m_wdata[8*i +: 8];
            if (m_cnt == m_len + 1) m_busy <= 1'b0;
            else                    m_cnt  <= m_cnt + 1;
        end
    end

    logic        e_acc, e_ack;
    logic [41:0] e_rf;
    logic [33:0] e_m0, e_m1;
    always_comb begin
        e_acc = m_busy && (m_cnt <= m_len);
        e_ack = m_busy && (m_cnt == m_len + 1);
        e_rf  = e_acc ? {1'b1, m_write, !m_write, m_addr, m_size, m_wdata} : 42'd0;
        e_m0  = (e_ack && !m_id) ? {1'b1, m_err, m_rd} : 34'd0;
        e_m1  = (e_ack &&  m_id) ? {1'b1, m_err, m_rd} : 34'd0;
    end

    // Every-cycle compare, sampled on the falling edge.
    int we_cnt = 0, en_cnt = 0;
    logic [4:0] we_addr;
    logic [1:0] we_size;
    always @(negedge clk) begin
        check("m0_rsp", {m0_if.ack, m0_if.err, m0_if.rdata}, e_m0);
        check("m1_rsp", {m1_if.ack, m1_if.err, m1_if.rdata}, e_m1);
        check("rf_bus", {rf_if.en, rf_if.we, rf_if.re, rf_if.addr, rf_if.size, rf_if.wd_data}, e_rf);
    end

    always @(negedge clk) begin
        if (rf_if.we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= rf_if.addr;
            we_size <= rf_if.size;
        end
        if (rf_if.en) en_cnt <= en_cnt + 1;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit id, input bit r, input logic [4:0] a, input logic [1:0] s,
                         input bit w, input logic [31:0] d);
        if (id) begin
            m1_if.req = r; m1_if.addr = a; m1_if.size = s; m1_if.write = w; m1_if.wdata = d;
        end else begin
            m0_if.req = r; m0_if.addr = a; m0_if.size = s; m0_if.write = w; m0_if.wdata = d;
        end
    endtask

    // Issued from an IDLE cycle; returns cycles from request cycle T to its ack.
    task automatic txn(input bit id, input logic [4:0] a, input logic [1:0] s, input bit w,
                       input logic [31:0] d, output int lat, output logic [31:0] rd, output logic e);
        drive(id, 1'b1, a, s, w, d);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(id ? m1_if.ack : m0_if.ack) && lat < 100);
        rd = id ? m1_if.rdata : m0_if.rdata;
        e  = id ? m1_if.err   : m0_if.err;
        drive(id, 1'b0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
    endtask

    int lat, en0, we0, nack;
    logic [31:0] rd;
    logic e;
    int ack_id[8];
    int ack_cyc[8];
    bit jack[2];

    task automatic new_cmd(input bit id);
        drive(id, 1'b1, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
    endtask

    function automatic int pick_stall();
        int r;
        r = $urandom_range(0, 9);
        return (r <= 5) ? r % 3 : (r == 6) ? 15 : (r == 7) ? 16 : (r == 8) ? 255 : 4;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 8'h00; mmem[i] = 8'h00; end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {m0_if.ack, m1_if.ack, m0_if.err, m1_if.err, rf_if.en, rf_if.we, rf_if.re}, 7'd0);
        rst = 1'b0;

        // Word write then read back.
        we0 = we_cnt;
        txn(1'b0, 5'd4, 2'd2, 1'b1, 32'hDEADBEEF, lat, rd, e);
        check("wr_lat", lat, 2);
        check("wr_err", e, 0);
        check("wr_we_cycles", we_cnt - we0, 1);
        check("wr_we_addr_size", {we_addr, we_size}, {5'd4, 2'd2});
        txn(1'b0, 5'd4, 2'd2, 1'b0, 32'd0, lat, rd, e);
        check("rd_lat", lat, 2);
        check("rd_data", {e, rd}, {1'b0, 32'hDEADBEEF});

        // Misaligned halfword at the top address.
        txn(1'b1, 5'd31, 2'd0, 1'b1, 32'h0000005A, lat, rd, e);
        check("b31_wr_err", e, 0);
        txn(1'b1, 5'd31, 2'd1, 1'b0, 32'd0, lat, rd, e);
        check("h31_rd", {e, rd}, {1'b1, 32'd0});
        txn(1'b1, 5'd31, 2'd1, 1'b1, 32'h0000FFFF, lat, rd, e);
        check("h31_wr_err", e, 1);
        txn(1'b1, 5'd31, 2'd0, 1'b0, 32'd0, lat, rd, e);
        check("b31_rd", {e, rd}, {1'b0, 32'h0000005A});

        // Illegal size never reaches the register file.
        en0 = en_cnt;
        txn(1'b0, 5'd3, 2'd3, 1'b0, 32'd0, lat, rd, e);
        check("ill_lat", lat, 1);
        check("ill_rsp", {e, rd}, {1'b1, 32'd0});
        check("ill_no_en", en_cnt - en0, 0);

        // Wait states and timeout.
        stall_cfg = 255;
        txn(1'b0, 5'd4, 2'd2, 1'b0, 32'd0, lat, rd, e);
        check("to_lat", lat, 17);
        check("to_rsp", {e, rd}, {1'b1, 32'd0});
        stall_cfg = 3;
        txn(1'b0, 5'd4, 2'd2, 1'b0, 32'd0, lat, rd, e);
        check("st3_lat", lat, 5);
        check("st3_rsp", {e, rd}, {1'b0, 32'hDEADBEEF});
        stall_cfg = 15;
        txn(1'b0, 5'd4, 2'd1, 1'b0, 32'd0, lat, rd, e);
        check("st15_lat", lat, 17);
        check("st15_rsp", {e, rd}, {1'b0, 32'h0000BEEF});

        // Reset in the middle of an access.
        stall_cfg = 255;
        drive(1'b0, 1'b1, 5'd4, 2'd2, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outs", {m0_if.ack, m1_if.ack, rf_if.en, rf_if.re}, 4'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        stall_cfg = 0;

        // Tie held from reset: alternating grants every third cycle.
        drive(1'b0, 1'b1, 5'd4, 2'd2, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 5'd8, 2'd2, 1'b0, 32'd0);
        nack = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (m0_if.ack && nack < 8) begin ack_id[nack] = 0; ack_cyc[nack] = c; nack++; end
            if (m1_if.ack && nack < 8) begin ack_id[nack] = 1; ack_cyc[nack] = c; nack++; end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
        check("tie_nack", nack, 4);
        for (int k = 0; k < 4; k++) begin
            check("tie_id", ack_id[k], k % 2);
            check("tie_cyc", ack_cyc[k], 2 + 3 * k);
        end
        repeat (2) @(posedge clk);
        #1;

        // Random traffic against the model.
        jack[0] = 1'b0; jack[1] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (m0_if.ack || m1_if.ack) stall_cfg = pick_stall();
            for (int i = 0; i < 2; i++) begin
                if (jack[i]) begin
                    jack[i] = 1'b0;
                    if ($urandom_range(0, 1) != 0) new_cmd(1'(i));
                    else drive(1'(i), 1'b0, '0, '0, 1'b0, '0);
                end else if (i == 0 ? m0_if.ack : m1_if.ack) begin
                    jack[i] = 1'b1;
                end else if (!(i == 0 ? m0_if.req : m1_if.req) && $urandom_range(0, 2) == 0) begin
                    new_cmd(1'(i));
                end
            end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
        repeat (40) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
